gshare_predictor: RTL and testbench

Global-history (gshare) branch direction predictor for the CPU fetch/decode path. It combinationally predicts taken/not-taken for the instruction at `branch_address` by XOR-ing that address with an 8-bit global history register (GHR) to index a 256-entry table of 2-bit saturating counters. When a branch resolves, it is trained through a separate update port. JAL and JALR are always predicted taken.

---
 rtl/bp_pkg.sv | 17 +
 rtl/gshare_pht.sv | 39 +++
 rtl/gshare_predictor.sv | 62 ++++++
 tb/tb_gshare_predictor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictors: RV32I control-transfer opcodes
// and the 2-bit saturating counter type.
package bp_pkg;

  localparam int ADDR_W = 8;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_SNT = 2'b00;
  localparam ctr2_t CTR_WNT = 2'b01;
  localparam ctr2_t CTR_ST  = 2'b11;

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: 2-bit saturating counters, one asynchronous read port
// and one synchronous saturating-update write port.
module gshare_pht import bp_pkg::*; #(
  parameter int IDX_W = 8,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr2_t            rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  ctr2_t pht [DEPTH];

  function automatic ctr2_t sat_update(input ctr2_t c, input logic taken);
    ctr2_t r;
    r = c;
    if (taken) begin
      if (c != CTR_ST) r = c + 2'd1;
    end else begin
      if (c != CTR_SNT) r = c - 2'd1;
    end
    return r;
  endfunction

  assign rd_ctr = pht[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pht[i] <= CTR_WNT;
    end else if (wr_en) begin
      pht[wr_idx] <= sat_update(pht[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: global history XOR PC indexes the PHT; JAL/JALR
// always predicted taken, only resolved BRANCH opcodes train the table.
module gshare_predictor #(
  parameter int ADDR_W    = 8,
  parameter int GHR_W     = 8,
  parameter int PHT_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] branch_address,
  input  logic              update,
  input  logic [ADDR_W-1:0] update_address,
  input  logic              branch_taken,
  input  logic [6:0]        opcode,
  output logic              prediction
);
  import bp_pkg::*;

  logic [GHR_W-1:0]  ghr;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic              is_branch;
  logic              is_jump;
  logic              train;
  ctr2_t             rd_ctr;

  assign is_branch = (opcode == OP_BRANCH);
  assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign train     = update && is_branch;

  // GHR_W equals ADDR_W, so the XOR is a plain bitwise fold with no carry.
  assign rd_idx = branch_address ^ ghr;
  assign wr_idx = update_address ^ ghr;

  always_comb begin
    prediction = 1'b0;
    if (start) begin
      if (is_jump)        prediction = 1'b1;
      else if (is_branch) prediction = rd_ctr[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        ghr <= '0;
    else if (train) ghr <= {ghr[GHR_W-2:0], branch_taken};
  end

  gshare_pht #(
    .IDX_W (ADDR_W),
    .DEPTH (PHT_DEPTH)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx),
    .rd_ctr   (rd_ctr),
    .wr_en    (train),
    .wr_idx   (wr_idx),
    .wr_taken (branch_taken)
  );

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed plus randomized bench for gshare_predictor against an integer-array
// model of the history register and counter table.
module tb_gshare_predictor;
  import bp_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] branch_address = '0;
  logic       update = 1'b0;
  logic [7:0] update_address = '0;
  logic       branch_taken = 1'b0;
  logic [6:0] opcode = '0;
  logic       prediction;

  int checks = 0;
  int failures = 0;

  int m_pht [256];
  int m_ghr;

  gshare_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .branch_address (branch_address),
    .update         (update),
    .update_address (update_address),
    .branch_taken   (branch_taken),
    .opcode         (opcode),
    .prediction     (prediction)
  );

  always #5 clk = ~clk;

  function automatic int model_pred(input int st, input int ba, input logic [6:0] op);
    if (st == 0) return 0;
    if (op == OP_JAL || op == OP_JALR) return 1;
    if (op == OP_BRANCH) return (m_pht[(ba ^ m_ghr) % 256] >= 2) ? 1 : 0;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    m_ghr = 0;
  endtask

  task automatic model_edge(input int rs, input int up, input int ua, input int tk,
                            input logic [6:0] op);
    int idx;
    if (rs != 0) begin
      model_reset();
    end else if (up != 0 && op == OP_BRANCH) begin
      idx = (ua ^ m_ghr) % 256;
      if (tk != 0) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
      else         m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
      m_ghr = ((m_ghr * 2) + tk) % 256;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive after the falling edge, check the combinational
  // prediction against the pre-edge model, then advance the model at the edge.
  task automatic cyc(input string tag, input int rs, input int st, input int ba,
                     input int up, input int ua, input int tk, input logic [6:0] op);
    @(negedge clk);
    rst = (rs != 0);
    start = (st != 0);
    branch_address = 8'(ba);
    update = (up != 0);
    update_address = 8'(ua);
    branch_taken = (tk != 0);
    opcode = op;
    #1;
    chk(tag, int'(prediction), model_pred(st, ba, op));
    @(posedge clk);
    model_edge(rs, up, ua, tk, op);
    #1;
  endtask

  task automatic chk_ghr(input string tag);
    chk(tag, int'(dut.ghr), m_ghr);
  endtask

  task automatic chk_pht(input string tag, input int idx);
    chk(tag, int'(dut.u_pht.pht[idx]), m_pht[idx]);
  endtask

  logic [6:0] ops [4];

  initial begin
    ops[0] = OP_BRANCH; ops[1] = OP_JAL; ops[2] = OP_JALR; ops[3] = 7'b0110011;
    model_reset();

    // Reset and first lookup
    cyc("rst0", 1, 0, 0, 0, 0, 0, OP_BRANCH);
    chk("rst_ghr", int'(dut.ghr), 0);
    chk("rst_pht4", int'(dut.u_pht.pht[4]), 1);
    cyc("lookup4_reset", 0, 1, 4, 0, 0, 0, OP_BRANCH);
    chk("lookup4_reset_const", int'(prediction), 0);

    // One taken update at address 4
    cyc("upd4_taken", 0, 0, 0, 1, 4, 1, OP_BRANCH);
    chk("ghr_after_upd", int'(dut.ghr), 1);
    chk("pht4_after_upd", int'(dut.u_pht.pht[4]), 2);
    cyc("lookup4_idx5", 0, 1, 4, 0, 0, 0, OP_BRANCH);
    cyc("lookup5_idx4", 0, 1, 5, 0, 0, 0, OP_BRANCH);
    @(negedge clk);
    start = 1'b1; branch_address = 8'd5; opcode = OP_BRANCH; update = 1'b0;
    #1;
    chk("lookup5_const", int'(prediction), 1);

    // Jumps always taken when started, zero otherwise; updates with JALR ignored
    for (int i = 0; i < 4; i++) begin
      cyc("jalr_taken", 0, 1, int'($urandom_range(0, 255)), 0, 0, 0, OP_JALR);
      cyc("jal_taken", 0, 1, int'($urandom_range(0, 255)), 0, 0, 0, OP_JAL);
    end
    cyc("jal_nostart", 0, 0, 7, 0, 0, 0, OP_JAL);
    cyc("jalr_update", 0, 1, 9, 1, 4, 1, OP_JALR);
    chk("ghr_jalr_upd", int'(dut.ghr), 1);
    chk("pht4_jalr_upd", int'(dut.u_pht.pht[4]), 2);
    chk("pht5_jalr_upd", int'(dut.u_pht.pht[5]), 1);

    // Saturate high at index FF
    cyc("rst1", 1, 0, 0, 0, 0, 0, OP_BRANCH);
    for (int i = 0; i < 8; i++) cyc("sat_hi_fill", 0, 0, 0, 1, 0, 1, OP_BRANCH);
    chk("ghr_ff", int'(dut.ghr), 255);
    chk("phtff_start", int'(dut.u_pht.pht[255]), 1);
    cyc("sat_hi1", 0, 0, 0, 1, 0, 1, OP_BRANCH);
    chk("phtff_1", int'(dut.u_pht.pht[255]), 2);
    cyc("sat_hi2", 0, 0, 0, 1, 0, 1, OP_BRANCH);
    chk("phtff_2", int'(dut.u_pht.pht[255]), 3);
    cyc("sat_hi3", 0, 0, 0, 1, 0, 1, OP_BRANCH);
    chk("phtff_3", int'(dut.u_pht.pht[255]), 3);
    cyc("lookup0_ff", 0, 1, 0, 0, 0, 0, OP_BRANCH);
    chk("lookup0_ff_const", int'(prediction), 1);

    // Saturate low at index 4
    cyc("rst2", 1, 0, 0, 0, 0, 0, OP_BRANCH);
    cyc("sat_lo1", 0, 0, 0, 1, 4, 0, OP_BRANCH);
    chk("pht4_lo1", int'(dut.u_pht.pht[4]), 0);
    cyc("sat_lo2", 0, 0, 0, 1, 4, 0, OP_BRANCH);
    chk("pht4_lo2", int'(dut.u_pht.pht[4]), 0);
    chk("ghr_lo", int'(dut.ghr), 0);
    cyc("lookup4_lo", 0, 1, 4, 0, 0, 0, OP_BRANCH);

    // Same-cycle lookup and update, then reset overriding an update
    cyc("rst3", 1, 0, 0, 0, 0, 0, OP_BRANCH);
    cyc("same_cycle", 0, 1, 4, 1, 4, 1, OP_BRANCH);
    cyc("after_same5", 0, 1, 5, 0, 0, 0, OP_BRANCH);
    cyc("rst_with_upd", 1, 1, 5, 1, 5, 1, OP_BRANCH);
    chk("ghr_rst_upd", int'(dut.ghr), 0);
    for (int i = 0; i < 256; i++) chk_pht("pht_rst_all", i);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int rs;
      int idx;
      rs = ($urandom_range(0, 99) == 0) ? 1 : 0;
      cyc("rand_pred", rs, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 1)), ops[$urandom_range(0, 3)]);
      chk_ghr("rand_ghr");
      idx = int'($urandom_range(0, 255));
      chk_pht("rand_pht", idx);
    end
    for (int i = 0; i < 256; i++) chk_pht("final_pht", i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
